// File: rtl/fifo_read_ctrl.sv
// Async FIFO read side: read pointer, write-pointer sync, empty flag, output register.
// Optional synchronised fill level on o_rd_level when FIFO_RD_LEVEL_EN is defined.
module fifo_read_ctrl #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int ADDR  = 4
) (
  input  logic             i_rclk,
  input  logic             i_rrst,
  input  logic [ADDR:0]    i_wptr_gray,
  input  logic [WIDTH-1:0] i_RD_Data,
  output logic [ADDR-1:0]  o_raddr,
  output logic [ADDR:0]    o_rptr_gray,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
`ifdef FIFO_RD_LEVEL_EN
  output logic [ADDR:0]    o_rd_level,
`endif
  output logic             o_empty
);

  localparam logic [ADDR:0] ONE = 1;

  if (DEPTH != (1 << ADDR)) begin : g_bad_depth
    $error("DEPTH must equal 2**ADDR");
  end

  logic [ADDR:0] wq1, wq2;
  logic [ADDR:0] rbin, rgray;
  logic [ADDR:0] rbin_nxt, rgray_nxt;
  logic          pop;

  // two-flop synchroniser for the write pointer
  always_ff @(posedge i_rclk) begin
    if (i_rrst) begin
      wq1 <= '0;
      wq2 <= '0;
    end else begin
      wq1 <= i_wptr_gray;
      wq2 <= wq1;
    end
  end

  // empty and pop decode from registered state only
  always_comb begin
    o_empty   = (rgray == wq2);
    pop       = !o_empty && (!o_valid || i_ready);
    rbin_nxt  = rbin + ONE;
    rgray_nxt = rbin_nxt ^ (rbin_nxt >> 1);
  end

  // read pointer and output register; pop refills, consume drains
  always_ff @(posedge i_rclk) begin
    if (i_rrst) begin
      rbin    <= '0;
      rgray   <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
    end else if (pop) begin
      rbin    <= rbin_nxt;
      rgray   <= rgray_nxt;
      o_data  <= i_RD_Data;
      o_valid <= 1'b1;
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

  assign o_raddr     = rbin[ADDR-1:0];
  assign o_rptr_gray = rgray;

`ifdef FIFO_RD_LEVEL_EN
  logic [ADDR:0] wbin_s;

  // Gray-to-binary of the synchronised write pointer
  always_comb begin
    wbin_s = '0;
    for (int i = 0; i <= ADDR; i++) begin
      wbin_s[i] = ^(wq2 >> i);
    end
  end

  assign o_rd_level = wbin_s - rbin;
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl.
// Storage array modelled as a bench-side memory read at o_raddr.
module tb_fifo_read_ctrl;

  logic       clk = 1'b0;
  logic       rrst;
  logic [4:0] wptr;
  logic [7:0] rd_data;
  logic [3:0] raddr;
  logic [4:0] rptr;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       empty;
`ifdef FIFO_RD_LEVEL_EN
  logic [4:0] level;
`endif

  logic [7:0] mem [16];
  int         wbin;
  int         passed = 0;
  int         total  = 0;

  always #5 clk = ~clk;

  assign rd_data = mem[raddr];

  fifo_read_ctrl #(.DEPTH(16), .WIDTH(8), .ADDR(4)) dut (
    .i_rclk      (clk),
    .i_rrst      (rrst),
    .i_wptr_gray (wptr),
    .i_RD_Data   (rd_data),
    .o_raddr     (raddr),
    .o_rptr_gray (rptr),
    .o_data      (data),
    .o_valid     (valid),
    .i_ready     (ready),
`ifdef FIFO_RD_LEVEL_EN
    .o_rd_level  (level),
`endif
    .o_empty     (empty)
  );

  function automatic logic [4:0] gray(input int b);
    logic [4:0] x;
    x = b[4:0];
    return x ^ (x >> 1);
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    rrst  = 1'b1;
    ready = 1'b0;
    wbin  = 0;
    wptr  = '0;
    tick();
    rrst  = 1'b0;
  endtask

  task automatic test_reset;
    rrst  = 1'b1;
    ready = 1'b0;
    wptr  = 5'b00011;
    tick();
    tick();
    total++;
    if (empty !== 1'b1) $display("FAIL rst_empty got %b want 1", empty);
    else passed++;
    total++;
    if (valid !== 1'b0) $display("FAIL rst_valid got %b want 0", valid);
    else passed++;
    total++;
    if (data !== 8'h00) $display("FAIL rst_data got %h want 00", data);
    else passed++;
    total++;
    if (raddr !== 4'h0) $display("FAIL rst_raddr got %h want 0", raddr);
    else passed++;
    total++;
    if (rptr !== 5'b0) $display("FAIL rst_rptr got %b want 00000", rptr);
    else passed++;
    wptr = '0;
    wbin = 0;
    rrst = 1'b0;
    tick();
  endtask

  task automatic test_single;
    mem[0] = 8'hA5;
    ready  = 1'b0;
    wbin   = 1;
    wptr   = gray(1);
    tick();
    total++;
    if (empty !== 1'b1) $display("FAIL single_empty1 got %b want 1", empty);
    else passed++;
    tick();
    total++;
    if (empty !== 1'b0) $display("FAIL single_empty2 got %b want 0", empty);
    else passed++;
    total++;
    if (valid !== 1'b0) $display("FAIL single_valid2 got %b want 0", valid);
    else passed++;
    tick();
    total++;
    if (valid !== 1'b1) $display("FAIL single_valid3 got %b want 1", valid);
    else passed++;
    total++;
    if (data !== 8'hA5) $display("FAIL single_data got %h want a5", data);
    else passed++;
    total++;
    if (rptr !== 5'b00001) $display("FAIL single_rptr got %b want 00001", rptr);
    else passed++;
    tick();
    tick();
    total++;
    if (valid !== 1'b1 || data !== 8'hA5)
      $display("FAIL single_hold got %b/%h want 1/a5", valid, data);
    else passed++;
    total++;
    if (rptr !== 5'b00001 || empty !== 1'b1)
      $display("FAIL single_nopop got %b/%b want 00001/1", rptr, empty);
    else passed++;
    ready = 1'b1;
    tick();
    total++;
    if (valid !== 1'b0 || data !== 8'hA5)
      $display("FAIL single_consume got %b/%h want 0/a5", valid, data);
    else passed++;
    ready = 1'b0;
  endtask

  task automatic test_burst;
    bit pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int got = 0;
    do_reset();
    for (int i = 0; i < 4; i++) mem[i] = 8'h10 + 8'(i);
    wbin = 4;
    wptr = gray(4);
    for (int i = 0; i < 30; i++) begin
      ready = pat[i % 6];
      if (valid && ready) begin
        total++;
        if (data !== 8'h10 + 8'(got))
          $display("FAIL burst_data got %h want %h", data, 8'h10 + 8'(got));
        else passed++;
        got++;
      end
      tick();
    end
    ready = 1'b0;
    total++;
    if (got !== 4) $display("FAIL burst_count got %0d want 4", got);
    else passed++;
    total++;
    if (rptr !== gray(4)) $display("FAIL burst_rptr got %b want %b", rptr, gray(4));
    else passed++;
    total++;
    if (raddr !== 4'd4) $display("FAIL burst_raddr got %0d want 4", raddr);
    else passed++;
    total++;
    if (empty !== 1'b1 || valid !== 1'b0)
      $display("FAIL burst_end got %b/%b want 1/0", empty, valid);
    else passed++;
  endtask

  task automatic test_wrap;
    int  got = 0;
    bit  started = 0;
    do_reset();
    ready = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (valid) started = 1;
      if (started && got < 20) begin
        total++;
        if (valid !== 1'b1) $display("FAIL wrap_thru got %b want 1 at word %0d", valid, got);
        else passed++;
      end
      if (valid) begin
        total++;
        if (data !== 8'h40 + 8'(got))
          $display("FAIL wrap_data got %h want %h", data, 8'h40 + 8'(got));
        else passed++;
        total++;
        if (raddr !== 4'((got + 1) % 16))
          $display("FAIL wrap_raddr got %0d want %0d", raddr, (got + 1) % 16);
        else passed++;
        total++;
        if (rptr !== gray(got + 1))
          $display("FAIL wrap_rptr got %b want %b", rptr, gray(got + 1));
        else passed++;
        total++;
        if (rptr[4] !== (got >= 15))
          $display("FAIL wrap_msb got %b want %b", rptr[4], got >= 15);
        else passed++;
        got++;
      end
      if (wbin < 20) begin
        mem[wbin % 16] = 8'h40 + 8'(wbin);
        wbin = wbin + 1;
        wptr = gray(wbin);
      end
      tick();
    end
    ready = 1'b0;
    total++;
    if (got !== 20) $display("FAIL wrap_count got %0d want 20", got);
    else passed++;
    total++;
    if (empty !== 1'b1) $display("FAIL wrap_empty got %b want 1", empty);
    else passed++;
  endtask

  task automatic test_reset_mid;
    do_reset();
    mem[0] = 8'h3C;
    mem[1] = 8'h77;
    mem[2] = 8'h88;
    wbin   = 3;
    wptr   = gray(3);
    tick();
    tick();
    tick();
    total++;
    if (valid !== 1'b1 || data !== 8'h3C)
      $display("FAIL mid_pre got %b/%h want 1/3c", valid, data);
    else passed++;
    ready = 1'b1;
    rrst  = 1'b1;
    tick();
    ready = 1'b0;
    total++;
    if (valid !== 1'b0 || data !== 8'h00)
      $display("FAIL mid_rst got %b/%h want 0/00", valid, data);
    else passed++;
    total++;
    if (rptr !== 5'b0 || empty !== 1'b1)
      $display("FAIL mid_rst_ptr got %b/%b want 00000/1", rptr, empty);
    else passed++;
    rrst = 1'b0;
    tick();
    total++;
    if (empty !== 1'b1) $display("FAIL mid_sync1 got %b want 1", empty);
    else passed++;
    tick();
    total++;
    if (empty !== 1'b0) $display("FAIL mid_sync2 got %b want 0", empty);
    else passed++;
    tick();
    total++;
    if (valid !== 1'b1 || data !== 8'h3C)
      $display("FAIL mid_refill got %b/%h want 1/3c", valid, data);
    else passed++;
  endtask

`ifdef FIFO_RD_LEVEL_EN
  task automatic test_level;
    do_reset();
    total++;
    if (level !== 5'd0) $display("FAIL lvl_rst got %0d want 0", level);
    else passed++;
    wbin  = 2;
    wptr  = gray(2);
    ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (rptr !== gray(2) || valid !== 1'b0)
      $display("FAIL lvl_setup got %b/%b want %b/0", rptr, valid, gray(2));
    else passed++;
    ready = 1'b0;
    wbin  = 7;
    wptr  = gray(7);
    tick();
    tick();
    total++;
    if (level !== 5'd5) $display("FAIL lvl_five got %0d want 5", level);
    else passed++;
    do_reset();
    wbin = 16;
    wptr = gray(16);
    tick();
    tick();
    total++;
    if (level !== 5'd16) $display("FAIL lvl_full got %0d want 16", level);
    else passed++;
    total++;
    if (empty !== 1'b0) $display("FAIL lvl_full_empty got %b want 0", empty);
    else passed++;
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    rrst  = 1'b1;
    ready = 1'b0;
    wptr  = '0;
    wbin  = 0;
    @(negedge clk);
    test_reset();
    test_single();
    test_burst();
    test_wrap();
    test_reset_mid();
`ifdef FIFO_RD_LEVEL_EN
    test_level();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
